// File: rtl/pac_pkg.sv
// -----------------------------------------------------------------------------
// pac_pkg
// Shared definitions for the CORDIC phase-amplitude converter front end:
// sequencer state encoding, ROM geometry, phase-word field positions and the
// dither LFSR seed/taps with its step function.
// No ports (package).
// -----------------------------------------------------------------------------
package pac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } pac_state_e;

  localparam int ROM_AW  = 6;
  localparam int ROM_DW  = 48;
  localparam int PHASE_W = 16;

  // MSB positions of quadrant, ROM read address and CORDIC residual fields
  localparam int QUA_MSB = 15;
  localparam int REA_MSB = 12;
  localparam int COR_MSB = 6;

  // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = {1'b0, v[15:1]};
    if (v[0]) begin
      lfsr_step = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_step = shifted;
    end
  endfunction

endpackage

// File: rtl/pac_phase_driver_if.sv
// -----------------------------------------------------------------------------
// pac_phase_driver_if
// Bundles the frequency-control side (load channel, run control, ftw) and the
// converter side (ROM write port, phase word) of the phase driver.
//   master : the phase driver itself (consumes load/run inputs, drives ROM
//            write port, phase word and status)
//   slave  : the environment (frequency control + converter)
// Signals:
//   load_req, load_valid, load_data[47:0], load_ready  ROM load channel
//   run_en, ftw[ACC_W-1:0]                             accumulator control
//   cen, wen, index_wri[5:0], D[47:0]                  ROM write port (active-low)
//   index_qua[2:0], index_rea[5:0], index_cor[6:0]     phase word fields
//   wen_in                                             phase word valid strobe
//   loaded                                             ROM contents valid
// -----------------------------------------------------------------------------
interface pac_phase_driver_if #(
  parameter int ACC_W = 32
);
  import pac_pkg::*;

  logic                 load_req;
  logic                 load_valid;
  logic [ROM_DW-1:0]    load_data;
  logic                 load_ready;
  logic                 run_en;
  logic [ACC_W-1:0]     ftw;
  logic                 cen;
  logic                 wen;
  logic [ROM_AW-1:0]    index_wri;
  logic [ROM_DW-1:0]    D;
  logic [2:0]           index_qua;
  logic [5:0]           index_rea;
  logic [6:0]           index_cor;
  logic                 wen_in;
  logic                 loaded;

  modport master (
    input  load_req, load_valid, load_data, run_en, ftw,
    output load_ready, cen, wen, index_wri, D,
           index_qua, index_rea, index_cor, wen_in, loaded
  );

  modport slave (
    output load_req, load_valid, load_data, run_en, ftw,
    input  load_ready, cen, wen, index_wri, D,
           index_qua, index_rea, index_cor, wen_in, loaded
  );

endinterface

// File: rtl/pac_phase_acc.sv
// -----------------------------------------------------------------------------
// pac_phase_acc
// Phase accumulator with registered phase-word field split.
// Optional feature macro: PAC_PHASE_DITHER_EN (adds a 16-bit Galois LFSR value
// below the phase word before truncation; the accumulator is never modified).
// Ports:
//   clk, reset      clock, async active-low reset
//   step            add ftw this cycle and register the new phase word
//   clear           zero the accumulator (takes priority over step)
//   ftw             frequency tuning word
//   index_qua/rea/cor  registered phase word fields
// -----------------------------------------------------------------------------
module pac_phase_acc
  import pac_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             clear,
  input  logic [ACC_W-1:0] ftw,
  output logic [2:0]       index_qua,
  output logic [5:0]       index_rea,
  output logic [6:0]       index_cor
);

  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   acc_nxt_s;
  logic [PHASE_W-1:0] phase_s;

`ifdef PAC_PHASE_DITHER_EN
  logic [15:0]        lfsr_r;
  logic [ACC_W-1:0]   dith_sum_s;

  // Next accumulator value and dithered phase word (carry ripples into phase)
  always_comb begin
    acc_nxt_s  = acc_r + ftw;
    dith_sum_s = acc_nxt_s + {{(ACC_W-16){1'b0}}, lfsr_r};
    phase_s    = dith_sum_s[ACC_W-1 -: PHASE_W];
  end

  // Dither LFSR advances once per issued phase word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (step && !clear) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`else
  // Next accumulator value and its truncated phase word
  always_comb begin
    acc_nxt_s = acc_r + ftw;
    phase_s   = acc_nxt_s[ACC_W-1 -: PHASE_W];
  end
`endif

  // Accumulator and phase-word registers; fields land with the new acc value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r     <= '0;
      index_qua <= 3'd0;
      index_rea <= 6'd0;
      index_cor <= 7'd0;
    end else if (clear) begin
      acc_r     <= '0;
    end else if (step) begin
      acc_r     <= acc_nxt_s;
      index_qua <= phase_s[QUA_MSB -: 3];
      index_rea <= phase_s[REA_MSB -: 6];
      index_cor <= phase_s[COR_MSB -: 7];
    end else begin
      acc_r     <= acc_r;
    end
  end

endmodule

// File: rtl/pac_phase_driver.sv
// -----------------------------------------------------------------------------
// pac_phase_driver
// Front-end sequencer for the CORDIC phase-amplitude converter: loads the
// 64x48 coefficient ROM through its write port, then runs the phase
// accumulator issuing one aligned phase word per cycle.
// Optional feature macro: PAC_PHASE_DITHER_EN (see pac_phase_acc).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    pac_phase_driver_if.master (load channel, run control, ROM write
//          port, phase word, loaded status)
// -----------------------------------------------------------------------------
module pac_phase_driver
  import pac_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int ROM_DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  pac_phase_driver_if.master  bus
);

  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(ROM_DEPTH - 1);

  pac_state_e         state_r;
  logic [ROM_AW-1:0]  cnt_r;
  logic               cen_r;
  logic               wen_r;
  logic [ROM_AW-1:0]  index_wri_r;
  logic [ROM_DW-1:0]  d_r;
  logic               load_ready_r;
  logic               loaded_r;
  logic               wen_in_r;
  logic               step_s;
  logic               clear_s;

  // Accumulator control: load_req outside LOAD restarts from zero
  always_comb begin
    step_s  = 1'b0;
    clear_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_READY: begin
        clear_s = bus.load_req;
      end
      ST_RUN: begin
        if (bus.load_req) begin
          clear_s = 1'b1;
        end else begin
          step_s = bus.run_en;
        end
      end
      default: begin
        step_s  = 1'b0;
        clear_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered ROM write port, handshake and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 6'd0;
      cen_r        <= 1'b1;
      wen_r        <= 1'b1;
      index_wri_r  <= 6'd0;
      d_r          <= 48'd0;
      load_ready_r <= 1'b0;
      loaded_r     <= 1'b0;
      wen_in_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.load_req) begin
            state_r      <= ST_LOAD;
            cnt_r        <= 6'd0;
            load_ready_r <= 1'b1;
            loaded_r     <= 1'b0;
            cen_r        <= 1'b1;
            wen_r        <= 1'b1;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (bus.load_valid && load_ready_r) begin
            cen_r       <= 1'b0;
            wen_r       <= 1'b0;
            index_wri_r <= cnt_r;
            d_r         <= bus.load_data;
            if (cnt_r == LAST_IDX) begin
              // last word: handshake closes on the same edge the counter wraps
              cnt_r        <= 6'd0;
              load_ready_r <= 1'b0;
              state_r      <= ST_READY;
            end else begin
              cnt_r        <= cnt_r + 6'd1;
            end
          end else begin
            cen_r <= 1'b1;
            wen_r <= 1'b1;
          end
        end
        ST_READY: begin
          wen_in_r <= 1'b0;
          if (bus.load_req) begin
            state_r      <= ST_LOAD;
            cnt_r        <= 6'd0;
            load_ready_r <= 1'b1;
            loaded_r     <= 1'b0;
            cen_r        <= 1'b1;
            wen_r        <= 1'b1;
          end else begin
            // first READY cycle still shows the final write strobe
            cen_r    <= 1'b0;
            wen_r    <= 1'b1;
            loaded_r <= 1'b1;
            if (bus.run_en) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_READY;
            end
          end
        end
        ST_RUN: begin
          if (bus.load_req) begin
            state_r      <= ST_LOAD;
            cnt_r        <= 6'd0;
            load_ready_r <= 1'b1;
            loaded_r     <= 1'b0;
            cen_r        <= 1'b1;
            wen_r        <= 1'b1;
            wen_in_r     <= 1'b0;
          end else if (!bus.run_en) begin
            state_r  <= ST_READY;
            wen_in_r <= 1'b0;
          end else begin
            wen_in_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  pac_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .step      (step_s),
    .clear     (clear_s),
    .ftw       (bus.ftw),
    .index_qua (bus.index_qua),
    .index_rea (bus.index_rea),
    .index_cor (bus.index_cor)
  );

  assign bus.cen        = cen_r;
  assign bus.wen        = wen_r;
  assign bus.index_wri  = index_wri_r;
  assign bus.D          = d_r;
  assign bus.load_ready = load_ready_r;
  assign bus.loaded     = loaded_r;
  assign bus.wen_in     = wen_in_r;

endmodule
